// File: rtl/dpbram_sized.sv
// Byte-addressed true-dual-port RAM with 1/2/4/8-byte accesses, sign/zero-extending reads,
// misalignment errors, selectable read-during-write policy and 1- or 2-cycle read latency.
module dpbram_sized #(
   parameter int unsigned ADDR_BW     = 10,
   parameter int unsigned DATA_BW     = 32,
   parameter int unsigned RD_LATENCY  = 1,
   parameter int unsigned WRITE_FIRST = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_w_en_p0,
   input  logic [ADDR_BW-1:0] i_w_addr_p0,
   input  logic [1:0]         i_w_size_p0,
   input  logic [DATA_BW-1:0] i_w_data_p0,
   input  logic               i_r_en_p0,
   input  logic [ADDR_BW-1:0] i_r_addr_p0,
   input  logic [1:0]         i_r_size_p0,
   input  logic               i_r_signed_p0,
   output logic [DATA_BW-1:0] o_r_data_p0,
   output logic               o_r_valid_p0,
   output logic               o_r_err_p0,
   output logic               o_w_err_p0,
   input  logic               i_w_en_p1,
   input  logic [ADDR_BW-1:0] i_w_addr_p1,
   input  logic [1:0]         i_w_size_p1,
   input  logic [DATA_BW-1:0] i_w_data_p1,
   input  logic               i_r_en_p1,
   input  logic [ADDR_BW-1:0] i_r_addr_p1,
   input  logic [1:0]         i_r_size_p1,
   input  logic               i_r_signed_p1,
   output logic [DATA_BW-1:0] o_r_data_p1,
   output logic               o_r_valid_p1,
   output logic               o_r_err_p1,
   output logic               o_w_err_p1
);

   localparam int unsigned NB     = DATA_BW / 8;
   localparam int unsigned BO     = $clog2(NB);
   localparam int unsigned WORD_W = ADDR_BW - BO;
   localparam int unsigned WORDS  = 2 ** WORD_W;
   localparam bit          FWD    = (WRITE_FIRST != 0);

   logic [1:0]                    w_en, r_en, r_sgn;
   logic [1:0][ADDR_BW-1:0]       w_addr, r_addr;
   logic [1:0][1:0]               w_size, r_size;
   logic [1:0][DATA_BW-1:0]       w_data;
   logic [1:0][WORD_W-1:0]        w_idx, r_idx;
   logic [1:0]                    w_bad, r_legal;
   logic [1:0][NB-1:0]            lane_we;
   logic [1:0][NB-1:0][7:0]       lane_wd;
   logic [1:0][DATA_BW-1:0]       rd_word, rd_res;
   logic [1:0]                    s1_vld, s1_err, w_err;
   logic [1:0][DATA_BW-1:0]       s1_dat;
   logic [1:0]                    out_vld, out_err;
   logic [1:0][DATA_BW-1:0]       out_dat;

   assign w_en   = {i_w_en_p1, i_w_en_p0};
   assign w_addr = {i_w_addr_p1, i_w_addr_p0};
   assign w_size = {i_w_size_p1, i_w_size_p0};
   assign w_data = {i_w_data_p1, i_w_data_p0};
   assign r_en   = {i_r_en_p1, i_r_en_p0};
   assign r_addr = {i_r_addr_p1, i_r_addr_p0};
   assign r_size = {i_r_size_p1, i_r_size_p0};
   assign r_sgn  = {i_r_signed_p1, i_r_signed_p0};

   function automatic int unsigned offset_of(input logic [ADDR_BW-1:0] addr);
      return 32'(addr) & (NB - 1);
   endfunction

   function automatic logic legal(input int unsigned off, input logic [1:0] size);
      return (32'(size) <= BO) && ((off & ((32'd1 << size) - 32'd1)) == 32'd0);
   endfunction

   // Shift the addressed bytes down, then fill above the access width with sign or zero.
   function automatic logic [DATA_BW-1:0] extract(input logic [DATA_BW-1:0] word,
                                                  input int unsigned off,
                                                  input logic [1:0] size,
                                                  input logic sgn);
      logic [DATA_BW-1:0] sh;
      logic [DATA_BW-1:0] res;
      int unsigned        nbits;
      logic               fill;
      sh    = word >> (8 * off);
      nbits = 32'd8 << size;
      fill  = sgn & sh[(nbits - 1) & (DATA_BW - 1)];
      for (int unsigned i = 0; i < DATA_BW; i++) res[i] = (i < nbits) ? sh[i] : fill;
      return res;
   endfunction

   for (genvar p = 0; p < 2; p++) begin : g_idx
      assign w_idx[p] = w_addr[p][ADDR_BW-1:BO];
      assign r_idx[p] = r_addr[p][ADDR_BW-1:BO];
   end

   // Per-lane write enables and lane-aligned write bytes; requests under reset are dropped.
   always_comb begin
      int unsigned off;
      int unsigned nbytes;
      lane_we = '0;
      lane_wd = '0;
      w_bad   = '0;
      for (int p = 0; p < 2; p++) begin
         off    = offset_of(w_addr[p]);
         nbytes = 32'd1 << w_size[p];
         if (legal(off, w_size[p])) begin
            for (int unsigned l = 0; l < NB; l++) begin
               lane_we[p][l] = w_en[p] && rst_n && (l >= off) && (l < off + nbytes);
               lane_wd[p][l] = 8'(w_data[p] >> (8 * ((l - off) & (NB - 1))));
            end
         end else begin
            w_bad[p] = w_en[p] && rst_n;
         end
      end
   end

   for (genvar l = 0; l < NB; l++) begin : g_lane
      logic [7:0] mem [WORDS];

      // p0 is written last so it wins on an overlapping lane of the same word.
      always_ff @(posedge clk) begin
         if (lane_we[1][l]) mem[w_idx[1]] <= lane_wd[1][l];
         if (lane_we[0][l]) mem[w_idx[0]] <= lane_wd[0][l];
      end

      for (genvar p = 0; p < 2; p++) begin : g_rd
         logic fwd0, fwd1;
         assign fwd0 = FWD && lane_we[0][l] && (w_idx[0] == r_idx[p]);
         assign fwd1 = FWD && lane_we[1][l] && (w_idx[1] == r_idx[p]);
         assign rd_word[p][l*8 +: 8] = fwd0 ? lane_wd[0][l] :
                                       fwd1 ? lane_wd[1][l] : mem[r_idx[p]];
      end
   end

   always_comb begin
      int unsigned off;
      for (int p = 0; p < 2; p++) begin
         off        = offset_of(r_addr[p]);
         r_legal[p] = legal(off, r_size[p]);
         rd_res[p]  = r_legal[p] ? extract(rd_word[p], off, r_size[p], r_sgn[p]) : '0;
      end
   end

   // First read stage; data only moves on a read so the output holds between reads.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld <= '0;
         s1_err <= '0;
         s1_dat <= '0;
         w_err  <= '0;
      end else begin
         s1_vld <= r_en;
         s1_err <= r_en & ~r_legal;
         w_err  <= w_bad;
         for (int p = 0; p < 2; p++) if (r_en[p]) s1_dat[p] <= rd_res[p];
      end
   end

   if (RD_LATENCY == 2) begin : g_lat2
      logic [1:0]              s2_vld, s2_err;
      logic [1:0][DATA_BW-1:0] s2_dat;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            s2_vld <= '0;
            s2_err <= '0;
            s2_dat <= '0;
         end else begin
            s2_vld <= s1_vld;
            s2_err <= s1_err;
            for (int p = 0; p < 2; p++) if (s1_vld[p]) s2_dat[p] <= s1_dat[p];
         end
      end

      assign out_vld = s2_vld;
      assign out_err = s2_err;
      assign out_dat = s2_dat;
   end else begin : g_lat1
      assign out_vld = s1_vld;
      assign out_err = s1_err;
      assign out_dat = s1_dat;
   end

   assign o_r_data_p0  = out_dat[0];
   assign o_r_valid_p0 = out_vld[0];
   assign o_r_err_p0   = out_err[0];
   assign o_w_err_p0   = w_err[0];
   assign o_r_data_p1  = out_dat[1];
   assign o_r_valid_p1 = out_vld[1];
   assign o_r_err_p1   = out_err[1];
   assign o_w_err_p1   = w_err[1];

endmodule

// File: tb/tb_dpbram_sized.sv
// Two instances share stimulus: a = read-first / latency 1, b = write-first / latency 2.
module tb_dpbram_sized;
   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          w_en0, w_en1, r_en0, r_en1, r_sgn0, r_sgn1;
   logic [AW-1:0] w_addr0, w_addr1, r_addr0, r_addr1;
   logic [1:0]    w_size0, w_size1, r_size0, r_size1;
   logic [DW-1:0] w_data0, w_data1;

   logic [DW-1:0] a_rd0, a_rd1, b_rd0, b_rd1;
   logic          a_rv0, a_rv1, a_re0, a_re1, a_we0, a_we1;
   logic          b_rv0, b_rv1, b_re0, b_re1, b_we0, b_we1;

   dpbram_sized #(.ADDR_BW(AW), .DATA_BW(DW), .RD_LATENCY(1), .WRITE_FIRST(0)) u_a (
      .clk(clk), .rst_n(rst_n),
      .i_w_en_p0(w_en0), .i_w_addr_p0(w_addr0), .i_w_size_p0(w_size0), .i_w_data_p0(w_data0),
      .i_r_en_p0(r_en0), .i_r_addr_p0(r_addr0), .i_r_size_p0(r_size0), .i_r_signed_p0(r_sgn0),
      .o_r_data_p0(a_rd0), .o_r_valid_p0(a_rv0), .o_r_err_p0(a_re0), .o_w_err_p0(a_we0),
      .i_w_en_p1(w_en1), .i_w_addr_p1(w_addr1), .i_w_size_p1(w_size1), .i_w_data_p1(w_data1),
      .i_r_en_p1(r_en1), .i_r_addr_p1(r_addr1), .i_r_size_p1(r_size1), .i_r_signed_p1(r_sgn1),
      .o_r_data_p1(a_rd1), .o_r_valid_p1(a_rv1), .o_r_err_p1(a_re1), .o_w_err_p1(a_we1));

   dpbram_sized #(.ADDR_BW(AW), .DATA_BW(DW), .RD_LATENCY(2), .WRITE_FIRST(1)) u_b (
      .clk(clk), .rst_n(rst_n),
      .i_w_en_p0(w_en0), .i_w_addr_p0(w_addr0), .i_w_size_p0(w_size0), .i_w_data_p0(w_data0),
      .i_r_en_p0(r_en0), .i_r_addr_p0(r_addr0), .i_r_size_p0(r_size0), .i_r_signed_p0(r_sgn0),
      .o_r_data_p0(b_rd0), .o_r_valid_p0(b_rv0), .o_r_err_p0(b_re0), .o_w_err_p0(b_we0),
      .i_w_en_p1(w_en1), .i_w_addr_p1(w_addr1), .i_w_size_p1(w_size1), .i_w_data_p1(w_data1),
      .i_r_en_p1(r_en1), .i_r_addr_p1(r_addr1), .i_r_size_p1(r_size1), .i_r_signed_p1(r_sgn1),
      .o_r_data_p1(b_rd1), .o_r_valid_p1(b_rv1), .o_r_err_p1(b_re1), .o_w_err_p1(b_we1));

   typedef struct packed {logic en; logic [AW-1:0] addr; logic [1:0] size; logic [DW-1:0] data;} wreq_t;
   typedef struct packed {logic en; logic [AW-1:0] addr; logic [1:0] size; logic sgn;} rreq_t;
   typedef struct packed {logic [DW-1:0] rf; logic [DW-1:0] wf; logic err;} rexp_t;
   typedef struct packed {wreq_t w0; wreq_t w1; rreq_t r0; rreq_t r1; rexp_t x0; rexp_t x1;
                          logic xwe0; logic xwe1;} vec_t;
   typedef struct packed {logic [DW-1:0] data; logic err; logic [31:0] due;} exp_t;

   localparam wreq_t WN = '0;
   localparam rreq_t RN = '0;
   localparam rexp_t XN = '0;
   localparam vec_t  IDLE = '0;

   function automatic wreq_t W(input logic [AW-1:0] a, input logic [1:0] s, input logic [DW-1:0] d);
      return '{1'b1, a, s, d};
   endfunction
   function automatic rreq_t R(input logic [AW-1:0] a, input logic [1:0] s, input logic g);
      return '{1'b1, a, s, g};
   endfunction
   function automatic rexp_t X(input logic [DW-1:0] rf, input logic [DW-1:0] wf, input logic e);
      return '{rf, wf, e};
   endfunction

   // Scoreboard queues: 0 = a.p0, 1 = a.p1, 2 = b.p0, 3 = b.p1.
   exp_t q [4][$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic rst_q = 1'b0;
   logic [DW-1:0] last [4] = '{default: '0};

   logic          mv [4];
   logic          me [4];
   logic [DW-1:0] md [4];
   assign mv[0] = a_rv0; assign mv[1] = a_rv1; assign mv[2] = b_rv0; assign mv[3] = b_rv1;
   assign me[0] = a_re0; assign me[1] = a_re1; assign me[2] = b_re0; assign me[3] = b_re1;
   assign md[0] = a_rd0; assign md[1] = a_rd1; assign md[2] = b_rd0; assign md[3] = b_rd1;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst_n;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         if (!rst_q) begin
            last[k] = '0;
            check($sformatf("reset_valid[%0d]", k), 64'(mv[k]), 64'd0);
            check($sformatf("reset_data[%0d]", k), 64'(md[k]), 64'd0);
            check($sformatf("reset_err[%0d]", k), 64'(me[k]), 64'd0);
         end else if (mv[k]) begin
            if (q[k].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid[%0d]: got valid=1 required 0 (cycle %0d)", k, cyc);
            end else begin
               e = q[k].pop_front();
               check($sformatf("rdata[%0d]", k), 64'(md[k]), 64'(e.data));
               check($sformatf("rerr[%0d]", k), 64'(me[k]), 64'(e.err));
               check($sformatf("latency[%0d]", k), 64'(cyc), 64'(e.due));
               last[k] = e.data;
            end
         end else begin
            check($sformatf("hold_data[%0d]", k), 64'(md[k]), 64'(last[k]));
            check($sformatf("idle_err[%0d]", k), 64'(me[k]), 64'd0);
            if (q[k].size() > 0 && int'(q[k][0].due) < cyc) begin
               e = q[k].pop_front();
               checks++;
               errors++;
               $display("FAIL missing_valid[%0d]: got valid=0 required 1 (due %0d)", k, e.due);
            end
         end
      end
   end

   // Drive one cycle of stimulus, queue its read expectations, then check the write errors.
   task automatic apply(input vec_t v, input bit push_b, input logic rst_v);
      @(negedge clk);
      rst_n  = rst_v;
      w_en0  = v.w0.en; w_addr0 = v.w0.addr; w_size0 = v.w0.size; w_data0 = v.w0.data;
      w_en1  = v.w1.en; w_addr1 = v.w1.addr; w_size1 = v.w1.size; w_data1 = v.w1.data;
      r_en0  = v.r0.en; r_addr0 = v.r0.addr; r_size0 = v.r0.size; r_sgn0  = v.r0.sgn;
      r_en1  = v.r1.en; r_addr1 = v.r1.addr; r_size1 = v.r1.size; r_sgn1  = v.r1.sgn;
      if (rst_v) begin
         if (v.r0.en) begin
            q[0].push_back('{v.x0.rf, v.x0.err, 32'(cyc + 1)});
            if (push_b) q[2].push_back('{v.x0.wf, v.x0.err, 32'(cyc + 2)});
         end
         if (v.r1.en) begin
            q[1].push_back('{v.x1.rf, v.x1.err, 32'(cyc + 1)});
            if (push_b) q[3].push_back('{v.x1.wf, v.x1.err, 32'(cyc + 2)});
         end
      end
      @(posedge clk);
      #1;
      check("a_w_err0", 64'(a_we0), 64'(v.xwe0));
      check("a_w_err1", 64'(a_we1), 64'(v.xwe1));
      check("b_w_err0", 64'(b_we0), 64'(v.xwe0));
      check("b_w_err1", 64'(b_we1), 64'(v.xwe1));
   endtask

   initial begin
      vec_t tbl [22];
      vec_t v;
      tbl[0]  = '{W(10'h010, 2, 32'hAABBCCDD), WN, RN, RN, XN, XN, 1'b0, 1'b0};
      tbl[1]  = '{WN, WN, R(10'h010, 2, 0), RN, X(32'hAABBCCDD, 32'hAABBCCDD, 0), XN, 1'b0, 1'b0};
      tbl[2]  = '{W(10'h013, 0, 32'hFFFFFF80), WN, RN, RN, XN, XN, 1'b0, 1'b0};
      tbl[3]  = '{WN, WN, R(10'h013, 0, 1), R(10'h013, 0, 0),
                  X(32'hFFFFFF80, 32'hFFFFFF80, 0), X(32'h00000080, 32'h00000080, 0), 1'b0, 1'b0};
      tbl[4]  = '{WN, WN, R(10'h012, 1, 0), R(10'h012, 1, 1),
                  X(32'h000080BB, 32'h000080BB, 0), X(32'hFFFF80BB, 32'hFFFF80BB, 0), 1'b0, 1'b0};
      tbl[5]  = '{W(10'h011, 2, 32'h12345678), W(10'h015, 1, 32'h0000FFFF), RN, RN, XN, XN, 1'b1, 1'b1};
      tbl[6]  = '{WN, WN, R(10'h010, 2, 0), R(10'h013, 1, 0),
                  X(32'h80BBCCDD, 32'h80BBCCDD, 0), X(32'h0, 32'h0, 1), 1'b0, 1'b0};
      tbl[7]  = '{WN, W(10'h018, 3, 32'hDEADBEEF), R(10'h010, 3, 0), RN, X(32'h0, 32'h0, 1), XN, 1'b0, 1'b1};
      tbl[8]  = '{W(10'h020, 2, 32'h11111111), WN, RN, RN, XN, XN, 1'b0, 1'b0};
      tbl[9]  = '{WN, W(10'h020, 0, 32'h00000022), R(10'h020, 2, 0), R(10'h010, 0, 0),
                  X(32'h11111111, 32'h11111122, 0), X(32'h000000DD, 32'h000000DD, 0), 1'b0, 1'b0};
      tbl[10] = '{WN, WN, R(10'h020, 2, 0), RN, X(32'h11111122, 32'h11111122, 0), XN, 1'b0, 1'b0};
      tbl[11] = '{W(10'h021, 0, 32'h000000A5), W(10'h021, 0, 32'h0000005A), RN, R(10'h020, 2, 0),
                  XN, X(32'h11111122, 32'h1111A522, 0), 1'b0, 1'b0};
      tbl[12] = '{WN, WN, R(10'h020, 2, 0), RN, X(32'h1111A522, 32'h1111A522, 0), XN, 1'b0, 1'b0};
      tbl[13] = '{W(10'h022, 0, 32'h00000033), W(10'h023, 0, 32'h00000044), RN, RN, XN, XN, 1'b0, 1'b0};
      tbl[14] = '{WN, WN, R(10'h020, 2, 0), R(10'h022, 1, 1),
                  X(32'h4433A522, 32'h4433A522, 0), X(32'h00004433, 32'h00004433, 0), 1'b0, 1'b0};
      tbl[15] = '{W(10'h030, 2, 32'h00000000), WN, RN, RN, XN, XN, 1'b0, 1'b0};
      tbl[16] = '{WN, W(10'h032, 1, 32'h1234BEEF), RN, RN, XN, XN, 1'b0, 1'b0};
      tbl[17] = '{WN, WN, R(10'h030, 2, 0), R(10'h032, 1, 1),
                  X(32'hBEEF0000, 32'hBEEF0000, 0), X(32'hFFFFBEEF, 32'hFFFFBEEF, 0), 1'b0, 1'b0};
      tbl[18] = '{W(10'h3FC, 2, 32'hCAFEF00D), WN, RN, RN, XN, XN, 1'b0, 1'b0};
      tbl[19] = '{WN, WN, R(10'h3FE, 1, 0), R(10'h3FC, 2, 1),
                  X(32'h0000CAFE, 32'h0000CAFE, 0), X(32'hCAFEF00D, 32'hCAFEF00D, 0), 1'b0, 1'b0};
      tbl[20] = '{W(10'h3FC, 0, 32'h000000EE), WN, RN, R(10'h3FC, 2, 0),
                  XN, X(32'hCAFEF00D, 32'hCAFEF0EE, 0), 1'b0, 1'b0};
      tbl[21] = '{WN, WN, R(10'h3FD, 0, 1), RN, X(32'hFFFFFFF0, 32'hFFFFFFF0, 0), XN, 1'b0, 1'b0};

      repeat (3) apply(IDLE, 1'b1, 1'b0);
      apply(IDLE, 1'b1, 1'b1);
      for (int i = 0; i < 22; i++) apply(tbl[i], 1'b1, 1'b1);

      // Fill two regions, then stream reads every cycle on both ports.
      for (int i = 0; i < 8; i++) begin
         v = IDLE;
         v.w0 = W(10'h040 + 10'(4 * i), 2, 32'hC0DE0000 + 32'(i * 273));
         v.w1 = W(10'h060 + 10'(4 * i), 2, 32'h5EED0000 + 32'(i));
         apply(v, 1'b1, 1'b1);
      end
      for (int i = 0; i < 8; i++) begin
         v = IDLE;
         v.r0 = R(10'h040 + 10'(4 * i), 2, 0);
         v.x0 = X(32'hC0DE0000 + 32'(i * 273), 32'hC0DE0000 + 32'(i * 273), 0);
         v.r1 = R(10'h060 + 10'(4 * (7 - i)), 2, 0);
         v.x1 = X(32'h5EED0000 + 32'(7 - i), 32'h5EED0000 + 32'(7 - i), 0);
         apply(v, 1'b1, 1'b1);
      end

      // Reset one cycle after a read: the latency-2 instance must drop it.
      v = IDLE;
      v.r0 = R(10'h010, 2, 0);
      v.x0 = X(32'h80BBCCDD, 32'h80BBCCDD, 0);
      apply(v, 1'b0, 1'b1);
      v = IDLE;
      v.w0 = W(10'h010, 2, 32'h0BADF00D);
      v.w1 = W(10'h011, 2, 32'h0);
      v.r0 = R(10'h010, 2, 0);
      v.r1 = R(10'h020, 2, 0);
      apply(v, 1'b1, 1'b0);
      apply(v, 1'b1, 1'b0);
      apply(IDLE, 1'b1, 1'b1);
      v = IDLE;
      v.r0 = R(10'h010, 2, 0);
      v.x0 = X(32'h80BBCCDD, 32'h80BBCCDD, 0);
      v.r1 = R(10'h3FC, 2, 0);
      v.x1 = X(32'hCAFEF0EE, 32'hCAFEF0EE, 0);
      apply(v, 1'b1, 1'b1);
      repeat (4) apply(IDLE, 1'b1, 1'b1);

      for (int k = 0; k < 4; k++) check($sformatf("drain[%0d]", k), 64'(q[k].size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
